// File: rtl/wvb_storage_ring_if.sv
// Bus bundle for wvb_storage_ring: waveform write port, RAM read port,
// header FIFO read side and overflow status.
interface wvb_storage_ring_if #(
  parameter int P_DATA_WIDTH      = 22,
  parameter int P_ADR_WIDTH       = 12,
  parameter int P_HDR_WIDTH       = 80,
  parameter int P_HDR_DEPTH_WIDTH = 8
) ();
  logic                                 wvb_wrreq;
  logic [P_DATA_WIDTH-1:0]              wvb_data_in;
  logic                                 eoe_in;
  logic [P_HDR_WIDTH-1:0]               hdr_data_in;
  logic [P_ADR_WIDTH-1:0]               wvb_rd_addr;
  logic [P_DATA_WIDTH-1:0]              wvb_data_out;
  logic                                 hdr_rdreq;
  logic [P_HDR_WIDTH+2*P_ADR_WIDTH-1:0] hdr_data_out;
  logic                                 hdr_empty;
  logic                                 hdr_full;
  logic [P_HDR_DEPTH_WIDTH:0]           n_wvf_in_buf;
  logic                                 wvb_overflow;
  logic [15:0]                          overflow_cnt;

  modport master (
    output wvb_wrreq, wvb_data_in, eoe_in, hdr_data_in, wvb_rd_addr, hdr_rdreq,
    input  wvb_data_out, hdr_data_out, hdr_empty, hdr_full, n_wvf_in_buf,
           wvb_overflow, overflow_cnt
  );

  modport slave (
    input  wvb_wrreq, wvb_data_in, eoe_in, hdr_data_in, wvb_rd_addr, hdr_rdreq,
    output wvb_data_out, hdr_data_out, hdr_empty, hdr_full, n_wvf_in_buf,
           wvb_overflow, overflow_cnt
  );
endinterface

// File: rtl/wvb_storage_ring.sv
// Waveform ring buffer with a header FIFO that owns the stored words until popped.
// Optional macro WVB_OVERFLOW_CNT_EN enables the saturating dropped-waveform counter.
module wvb_storage_ring #(
  parameter int P_DATA_WIDTH      = 22,
  parameter int P_ADR_WIDTH       = 12,
  parameter int P_HDR_WIDTH       = 80,
  parameter int P_HDR_DEPTH_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  wvb_storage_ring_if.slave bus
);
  localparam int ENTRY_W   = P_HDR_WIDTH + 2*P_ADR_WIDTH;
  localparam int RAM_DEPTH = 2**P_ADR_WIDTH;
  localparam int HDR_DEPTH = 2**P_HDR_DEPTH_WIDTH;
  localparam logic [P_ADR_WIDTH-1:0]       ADR_ONE = 1;
  localparam logic [P_HDR_DEPTH_WIDTH-1:0] IDX_ONE = 1;
  localparam logic [P_HDR_DEPTH_WIDTH:0]   CNT_ONE = 1;
  localparam logic [P_HDR_DEPTH_WIDTH:0]   CNT_MAX = HDR_DEPTH;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t                       state, state_nxt;
  logic [P_ADR_WIDTH-1:0]       wr_ptr, wr_ptr_nxt, wr_ptr_inc;
  logic [P_ADR_WIDTH-1:0]       start_addr, start_addr_nxt, free_ptr;
  logic                         ram_full, ram_we, push, pop, overflow_nxt;
  logic [P_DATA_WIDTH-1:0]      ram [RAM_DEPTH];
  logic [P_DATA_WIDTH-1:0]      wr_word;
  logic [ENTRY_W-1:0]           hdr_mem [HDR_DEPTH];
  logic [ENTRY_W-1:0]           push_entry, head_entry;
  logic [P_HDR_DEPTH_WIDTH-1:0] hdr_wr_idx, hdr_rd_idx;
  logic [P_HDR_DEPTH_WIDTH:0]   hdr_cnt;
  logic                         hdr_empty_i, hdr_full_i;
  logic                         unused_data_bit0;

  assign unused_data_bit0 = bus.wvb_data_in[0];
  assign wr_word    = {bus.wvb_data_in[P_DATA_WIDTH-1:1], bus.eoe_in};
  assign wr_ptr_inc = wr_ptr + ADR_ONE;
  assign ram_full   = (wr_ptr_inc == free_ptr);

  assign hdr_empty_i = (hdr_cnt == '0);
  assign hdr_full_i  = (hdr_cnt == CNT_MAX);
  assign pop         = bus.hdr_rdreq && !hdr_empty_i;
  assign head_entry  = hdr_mem[hdr_rd_idx];

  // A single-word waveform commits from IDLE, so its start is the current wr_ptr.
  assign push_entry = {(state == IDLE) ? wr_ptr : start_addr, wr_ptr, bus.hdr_data_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      start_addr <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      start_addr <= start_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    start_addr_nxt = start_addr;
    ram_we         = 1'b0;
    push           = 1'b0;
    overflow_nxt   = 1'b0;
    if (bus.wvb_wrreq) begin
      unique case (state)
        IDLE: begin
          start_addr_nxt = wr_ptr;
          if (hdr_full_i || ram_full) begin
            if (bus.eoe_in) overflow_nxt = 1'b1;
            else            state_nxt    = DROP;
          end else begin
            ram_we     = 1'b1;
            wr_ptr_nxt = wr_ptr_inc;
            if (bus.eoe_in) push      = 1'b1;
            else            state_nxt = WRITE;
          end
        end
        WRITE: begin
          if (ram_full) begin
            // Give back everything this waveform claimed.
            wr_ptr_nxt = start_addr;
            if (bus.eoe_in) begin
              overflow_nxt = 1'b1;
              state_nxt    = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end else begin
            ram_we     = 1'b1;
            wr_ptr_nxt = wr_ptr_inc;
            if (bus.eoe_in) begin
              push      = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        DROP: begin
          if (bus.eoe_in) begin
            overflow_nxt = 1'b1;
            state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && rst_n) ram[wr_ptr] <= wr_word;
    if (push) hdr_mem[hdr_wr_idx] <= push_entry;
  end

  // Output register stage: read data and overflow pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wvb_data_out <= '0;
      bus.wvb_overflow <= 1'b0;
    end else begin
      bus.wvb_data_out <= ram[bus.wvb_rd_addr];
      bus.wvb_overflow <= overflow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_wr_idx <= '0;
      hdr_rd_idx <= '0;
      hdr_cnt    <= '0;
      free_ptr   <= '0;
    end else begin
      if (push) hdr_wr_idx <= hdr_wr_idx + IDX_ONE;
      if (pop) begin
        hdr_rd_idx <= hdr_rd_idx + IDX_ONE;
        free_ptr   <= head_entry[P_HDR_WIDTH +: P_ADR_WIDTH] + ADR_ONE;
      end
      if (push && !pop)      hdr_cnt <= hdr_cnt + CNT_ONE;
      else if (pop && !push) hdr_cnt <= hdr_cnt - CNT_ONE;
    end
  end

  assign bus.hdr_data_out = head_entry;
  assign bus.hdr_empty    = hdr_empty_i;
  assign bus.hdr_full     = hdr_full_i;
  assign bus.n_wvf_in_buf = hdr_cnt;

`ifdef WVB_OVERFLOW_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] overflow_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                overflow_cnt_q <= '0;
    else if (bus.wvb_overflow) overflow_cnt_q <= sat_inc16(overflow_cnt_q);
  end

  assign bus.overflow_cnt = overflow_cnt_q;
`else
  assign bus.overflow_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_wvb_storage_ring.sv
// Directed bench for wvb_storage_ring with a 16-word ring and 4-entry header FIFO.
module tb_wvb_storage_ring;
  localparam int DW = 22;
  localparam int AW = 4;
  localparam int HW = 80;
  localparam int DDW = 2;

`ifdef WVB_OVERFLOW_CNT_EN
  localparam logic [15:0] CNT_AFTER_ONE_DROP = 16'd1;
`else
  localparam logic [15:0] CNT_AFTER_ONE_DROP = 16'd0;
`endif

  typedef struct {
    logic          wr;
    logic          eoe;
    logic [DW-1:0] d;
    logic [HW-1:0] h;
    logic          rd;
    logic [AW-1:0] ra;
    logic [DDW:0]  n;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          chk_hdr;
    logic [HW+2*AW-1:0] hdr_out;
    logic          chk_rd;
    logic [DW-1:0] rd_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[18];
  logic ovf_seen_early;

  wvb_storage_ring_if #(.P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW),
                        .P_HDR_DEPTH_WIDTH(DDW)) bus ();

  wvb_storage_ring #(.P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW),
                     .P_HDR_DEPTH_WIDTH(DDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic wr, input logic eoe, input logic [DW-1:0] d,
                              input logic [HW-1:0] h, input logic rd, input logic [AW-1:0] ra,
                              input logic [DDW:0] n, input logic empty, input logic full,
                              input logic ovf, input logic chk_hdr,
                              input logic [HW+2*AW-1:0] hdr_out, input logic chk_rd,
                              input logic [DW-1:0] rd_data);
    vec_t v;
    v.wr = wr; v.eoe = eoe; v.d = d; v.h = h; v.rd = rd; v.ra = ra;
    v.n = n; v.empty = empty; v.full = full; v.ovf = ovf;
    v.chk_hdr = chk_hdr; v.hdr_out = hdr_out; v.chk_rd = chk_rd; v.rd_data = rd_data;
    return v;
  endfunction

  function automatic logic [HW+2*AW-1:0] hdr(input logic [AW-1:0] s, input logic [AW-1:0] t,
                                             input logic [HW-1:0] h);
    return {s, t, h};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic eoe, input logic [DW-1:0] d,
                      input logic [HW-1:0] h, input logic rd, input logic [AW-1:0] ra);
    bus.wvb_wrreq   = wr;
    bus.eoe_in      = eoe;
    bus.wvb_data_in = d;
    bus.hdr_data_in = h;
    bus.hdr_rdreq   = rd;
    bus.wvb_rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input logic [AW-1:0] ra);
    step(1'b0, 1'b0, '0, '0, 1'b0, ra);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_step('0);
    idle_step('0);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " hdr_empty"}, 128'(bus.hdr_empty), 128'(1'b1));
    chk({tag, " hdr_full"}, 128'(bus.hdr_full), 128'(1'b0));
    chk({tag, " n_wvf"}, 128'(bus.n_wvf_in_buf), 128'(0));
    chk({tag, " overflow"}, 128'(bus.wvb_overflow), 128'(1'b0));
    chk({tag, " overflow_cnt"}, 128'(bus.overflow_cnt), 128'(0));
    chk({tag, " data_out"}, 128'(bus.wvb_data_out), 128'(0));
  endtask

  initial begin
    // After-edge expectations; ring holds 16 words, header FIFO holds 4.
    tbl[0]  = mk(1,0,22'h0A0,80'h0,   0,0, 0,1,0,0, 0,'0,0,'0);
    tbl[1]  = mk(1,0,22'h0B1,80'h0,   0,0, 0,1,0,0, 0,'0,0,'0);
    tbl[2]  = mk(1,0,22'h0C0,80'h0,   0,0, 0,1,0,0, 0,'0,0,'0);
    tbl[3]  = mk(1,1,22'h0D0,80'h1234,0,0, 1,0,0,0, 1,hdr(0,3,80'h1234),0,'0);
    tbl[4]  = mk(0,0,22'h0,  80'h0,   0,1, 1,0,0,0, 1,hdr(0,3,80'h1234),1,22'h0B0);
    tbl[5]  = mk(0,0,22'h0,  80'h0,   0,3, 1,0,0,0, 1,hdr(0,3,80'h1234),1,22'h0D1);
    tbl[6]  = mk(1,1,22'h100,80'hA1,  0,0, 2,0,0,0, 1,hdr(0,3,80'h1234),0,'0);
    tbl[7]  = mk(1,1,22'h200,80'hA2,  0,0, 3,0,0,0, 1,hdr(0,3,80'h1234),0,'0);
    tbl[8]  = mk(1,1,22'h300,80'hA3,  0,0, 4,0,1,0, 1,hdr(0,3,80'h1234),0,'0);
    tbl[9]  = mk(1,1,22'h400,80'hA4,  0,0, 4,0,1,1, 1,hdr(0,3,80'h1234),0,'0);
    tbl[10] = mk(0,0,22'h0,  80'h0,   0,6, 4,0,1,0, 0,'0,1,22'h301);
    tbl[11] = mk(0,0,22'h0,  80'h0,   1,0, 3,0,0,0, 1,hdr(4,4,80'hA1),0,'0);
    tbl[12] = mk(1,0,22'h500,80'h0,   0,0, 3,0,0,0, 1,hdr(4,4,80'hA1),0,'0);
    tbl[13] = mk(1,1,22'h600,80'hB0,  1,0, 3,0,0,0, 1,hdr(5,5,80'hA2),0,'0);
    tbl[14] = mk(0,0,22'h0,  80'h0,   1,0, 2,0,0,0, 1,hdr(6,6,80'hA3),0,'0);
    tbl[15] = mk(0,0,22'h0,  80'h0,   1,0, 1,0,0,0, 1,hdr(7,8,80'hB0),0,'0);
    tbl[16] = mk(0,0,22'h0,  80'h0,   1,8, 0,1,0,0, 0,'0,1,22'h601);
    tbl[17] = mk(0,0,22'h0,  80'h0,   1,4, 0,1,0,0, 0,'0,1,22'h101);

    do_reset();
    chk_reset_state("init");

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].eoe, tbl[i].d, tbl[i].h, tbl[i].rd, tbl[i].ra);
      chk($sformatf("v%0d n_wvf", i), 128'(bus.n_wvf_in_buf), 128'(tbl[i].n));
      chk($sformatf("v%0d hdr_empty", i), 128'(bus.hdr_empty), 128'(tbl[i].empty));
      chk($sformatf("v%0d hdr_full", i), 128'(bus.hdr_full), 128'(tbl[i].full));
      chk($sformatf("v%0d overflow", i), 128'(bus.wvb_overflow), 128'(tbl[i].ovf));
      if (tbl[i].chk_hdr)
        chk($sformatf("v%0d hdr_out", i), 128'(bus.hdr_data_out), 128'(tbl[i].hdr_out));
      if (tbl[i].chk_rd)
        chk($sformatf("v%0d rd_data", i), 128'(bus.wvb_data_out), 128'(tbl[i].rd_data));
      if (i == 13) chk("pop_push free_ptr", 128'(dut.free_ptr), 128'(5));
    end

    // 20-word waveform into an empty 16-word ring: word 16 hits the full mark.
    do_reset();
    ovf_seen_early = 1'b0;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b0, 22'((i + 1) << 4), '0, 1'b0, '0);
      if (bus.wvb_overflow) ovf_seen_early = 1'b1;
    end
    chk("drop no early overflow", 128'(ovf_seen_early), 128'(1'b0));
    step(1'b1, 1'b1, 22'h140, 80'hDD, 1'b0, '0);
    chk("drop overflow pulse", 128'(bus.wvb_overflow), 128'(1'b1));
    chk("drop hdr_empty", 128'(bus.hdr_empty), 128'(1'b1));
    idle_step('0);
    chk("drop overflow single", 128'(bus.wvb_overflow), 128'(1'b0));
    chk("drop overflow_cnt", 128'(bus.overflow_cnt), 128'(CNT_AFTER_ONE_DROP));
    step(1'b1, 1'b1, 22'h7F0, 80'hC1, 1'b0, '0);
    chk("drop rewind hdr", 128'(bus.hdr_data_out), 128'(hdr(0, 0, 80'hC1)));

    // Wrap: free_ptr moved to 14, then a 5-word waveform spans 14..2.
    do_reset();
    for (int i = 0; i < 14; i++)
      step(1'b1, (i == 13), 22'(i << 4), 80'hE0, 1'b0, '0);
    chk("wrap first hdr", 128'(bus.hdr_data_out), 128'(hdr(0, 13, 80'hE0)));
    step(1'b0, 1'b0, '0, '0, 1'b1, '0);
    chk("wrap pop empty", 128'(bus.hdr_empty), 128'(1'b1));
    for (int i = 0; i < 5; i++)
      step(1'b1, (i == 4), 22'((i + 1) << 8), 80'hE1, 1'b0, '0);
    chk("wrap hdr", 128'(bus.hdr_data_out), 128'(hdr(14, 2, 80'hE1)));
    chk("wrap n_wvf", 128'(bus.n_wvf_in_buf), 128'(1));
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] a;
      a = AW'(14 + i);
      idle_step(a);
      chk($sformatf("wrap rd %0d", a), 128'(bus.wvb_data_out),
          128'(22'((i + 1) << 8) | 22'(i == 4)));
    end

    // Reset on word 2 of a waveform.
    step(1'b1, 1'b0, 22'h040, '0, 1'b0, '0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 22'h050, '0, 1'b0, '0);
    chk_reset_state("midreset");
    rst_n = 1'b1;
    step(1'b1, 1'b1, 22'h060, 80'hF0, 1'b0, '0);
    chk("midreset restart hdr", 128'(bus.hdr_data_out), 128'(hdr(0, 0, 80'hF0)));
    chk("midreset restart n", 128'(bus.n_wvf_in_buf), 128'(1));
    idle_step('0);
    chk("midreset restart data", 128'(bus.wvb_data_out), 128'(22'h061));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wvb_storage_ring.md
WVB_STORAGE_RING -- requirements
Module: wvb_storage_ring

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 22: waveform word width; bit 0 carries the end-of-event flag.
REQ-002 SHALL have parameter P_ADR_WIDTH, default 12: waveform RAM address width; depth is 2^P_ADR_WIDTH words.
REQ-003 SHALL have parameter P_HDR_WIDTH, default 80: user header width.
REQ-004 SHALL have parameter P_HDR_DEPTH_WIDTH, default 8: header FIFO depth is 2^P_HDR_DEPTH_WIDTH entries.
REQ-005 SHALL have clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have wvb_wrreq  in  1  waveform word valid.
REQ-008 SHALL have wvb_data_in  in  P_DATA_WIDTH  waveform word; bit 0 is ignored and replaced by eoe_in.
REQ-009 SHALL have eoe_in  in  1  marks the last word of a waveform; qualified by wvb_wrreq.
REQ-010 SHALL have hdr_data_in  in  P_HDR_WIDTH  header, sampled on the last-word cycle.
REQ-011 SHALL have wvb_rd_addr  in  P_ADR_WIDTH  read address.
REQ-012 SHALL have wvb_data_out  out  P_DATA_WIDTH  registered RAM read data.
REQ-013 SHALL have hdr_rdreq  in  1  pop the head header and release its waveform words.
REQ-014 SHALL have hdr_data_out  out  P_HDR_WIDTH+2*P_ADR_WIDTH  FWFT head: {start_addr, stop_addr, header}.
REQ-015 SHALL have hdr_empty, hdr_full  out  1 each  header FIFO status.
REQ-016 SHALL have n_wvf_in_buf  out  P_HDR_DEPTH_WIDTH+1  headers stored, 0..2^P_HDR_DEPTH_WIDTH.
REQ-017 SHALL have wvb_overflow  out  1  one-cycle pulse per dropped waveform.
REQ-018 SHALL have overflow_cnt  out  16  dropped-waveform count (see Configuration).

Function
REQ-019 Write FSM SHALL have states IDLE, WRITE, DROP.
REQ-020 IDLE, wvb_wrreq=1: if hdr_full, go to DROP (or stay in IDLE if eoe_in=1) and pulse wvb_overflow on that waveform's eoe word; else latch start_addr=wr_ptr, write the word, and go to WRITE (or commit immediately if eoe_in=1).
REQ-021 Each accepted word SHALL be written at wr_ptr, which then advances by 1 modulo 2^P_ADR_WIDTH.
REQ-022 RAM SHALL be full when wr_ptr+1 == free_ptr; usable capacity is 2^P_ADR_WIDTH-1 words.
REQ-023 A word arriving while the RAM is full SHALL rewind wr_ptr to start_addr and move the FSM to DROP; that word is not written.
REQ-024 DROP SHALL discard words until an eoe word, then pulse wvb_overflow, return to IDLE, and push no header.
REQ-025 Commit, on the accepted eoe word: push {start_addr, address of the eoe word, hdr_data_in}; header visible at hdr_data_out with hdr_empty=0 on the next cycle.
REQ-026 hdr_rdreq with !hdr_empty SHALL pop the head and set free_ptr = popped stop_addr+1; hdr_rdreq while empty SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL both occur, leaving n_wvf_in_buf unchanged.
REQ-028 RAM read latency SHALL be 1 cycle: wvb_data_out = RAM[wvb_rd_addr of the previous cycle]; write and read of the same address in one cycle returns the old data.
REQ-029 n_wvf_in_buf SHALL equal the exact entry count, including 2^P_HDR_DEPTH_WIDTH when full.
REQ-030 Pointer arithmetic SHALL wrap modulo 2^P_ADR_WIDTH; a waveform with stop_addr < start_addr is legal.

Reset
REQ-031 rst_n=0 SHALL set FSM=IDLE, wr_ptr=free_ptr=0, header FIFO empty, hdr_empty=1, hdr_full=0, n_wvf_in_buf=0, wvb_overflow=0, overflow_cnt=0, wvb_data_out=0.
REQ-032 Reset mid-waveform SHALL discard the partial waveform with no header pushed; RAM contents are not cleared.

Configuration
REQ-033 With macro WVB_OVERFLOW_CNT_EN defined, overflow_cnt SHALL increment on each wvb_overflow pulse and saturate at 16'hFFFF.
REQ-034 Without WVB_OVERFLOW_CNT_EN, overflow_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-035 Reset, then a 4-word waveform (eoe on word 4) with hdr_data_in=80'h1234 -> next cycle hdr_empty=0, hdr_data_out={12'd0, 12'd3, 80'h1234}, n_wvf_in_buf=1.
REQ-036 P_ADR_WIDTH=4: 20-word waveform with no pop -> word 16 triggers the drop, wr_ptr returns to 0, wvb_overflow pulses once on the eoe word, hdr_empty stays 1, overflow_cnt=1 (macro on).
REQ-037 P_HDR_DEPTH_WIDTH=2: four 1-word waveforms -> hdr_full=1, n_wvf_in_buf=4; fifth waveform dropped, wvb_overflow pulses.
REQ-038 Last word of waveform B written in the same cycle that hdr_rdreq pops waveform A -> n_wvf_in_buf unchanged, free_ptr = A.stop+1, B header queued behind.
REQ-039 Wrap: with free_ptr=14 and P_ADR_WIDTH=4, a 5-word waveform starting at 14 -> header start=14, stop=2; reading addresses 14,15,0,1,2 returns the data with eoe=1 only on the last word.
REQ-040 rst_n=0 asserted on word 2 of a waveform -> all outputs at reset values; the next waveform starts at address 0.
